// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, 8 data bits LSB-first, optional parity, stop.
// All outputs are registered and derived from the next FSM state, so tx,
// tx_busy and tx_fsm_in_STOP_S change on the same edge as the state.
module uart_tx_frame #(
  parameter int unsigned BAUD_DIV   = 434,
  parameter int unsigned PARITY_EN  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_data_en,
  input  logic       tx_send_en,
  input  logic       tx_send,
  input  logic [7:0] Tx_Data_w,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_fsm_in_STOP_S
);

  localparam int unsigned     CW        = $clog2(BAUD_DIV);
  localparam logic [CW-1:0]   BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic            PAR_EN    = (PARITY_EN  != 32'd0) ? 1'b1 : 1'b0;
  localparam logic            PAR_ODD   = (PARITY_ODD != 32'd0) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Parity bit for a byte: even parity unless odd is selected.
  function automatic logic parity_of(input logic [7:0] d, input logic odd);
    parity_of = (^d) ^ odd;
  endfunction

  state_t        r_state;
  logic [7:0]    r_hold;
  logic [7:0]    r_shift;
  logic [CW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic          r_par;
  logic          r_tx;
  logic          r_busy;
  logic          r_stop;

  state_t        w_state_nx;
  logic [7:0]    w_hold_nx;
  logic [7:0]    w_shift_nx;
  logic [CW-1:0] w_baud_nx;
  logic [2:0]    w_bit_nx;
  logic          w_par_nx;
  logic          w_tx_nx;
  logic          w_bit_end;
  logic [7:0]    w_byte;

  // Next-state, datapath and registered-output values.
  always_comb begin
    w_state_nx = r_state;
    w_hold_nx  = tx_data_en ? Tx_Data_w : r_hold;
    w_shift_nx = r_shift;
    w_baud_nx  = r_baud;
    w_bit_nx   = r_bit;
    w_par_nx   = r_par;
    w_bit_end  = (r_baud == BAUD_LAST);
    // Same-cycle load wins over the stored byte so software can write and send together.
    w_byte     = tx_data_en ? Tx_Data_w : r_hold;

    case (r_state)
      S_IDLE: begin
        w_baud_nx = '0;
        w_bit_nx  = 3'd0;
        if (tx_send_en && tx_send) begin
          w_shift_nx = w_byte;
          w_par_nx   = parity_of(w_byte, PAR_ODD);
          w_state_nx = S_START;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_baud_nx  = '0;
          w_bit_nx   = 3'd0;
          w_state_nx = S_DATA;
        end else begin
          w_baud_nx = r_baud + CW'(1);
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_baud_nx = '0;
          if (r_bit == 3'd7) begin
            w_state_nx = PAR_EN ? S_PARITY : S_STOP;
          end else begin
            w_shift_nx = {1'b0, r_shift[7:1]};
            w_bit_nx   = r_bit + 3'd1;
          end
        end else begin
          w_baud_nx = r_baud + CW'(1);
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_baud_nx  = '0;
          w_state_nx = S_STOP;
        end else begin
          w_baud_nx = r_baud + CW'(1);
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_baud_nx  = '0;
          w_state_nx = S_IDLE;
        end else begin
          w_baud_nx = r_baud + CW'(1);
        end
      end
      default: begin
        w_baud_nx  = '0;
        w_bit_nx   = 3'd0;
        w_state_nx = S_IDLE;
      end
    endcase

    case (w_state_nx)
      S_IDLE:   w_tx_nx = 1'b1;
      S_START:  w_tx_nx = 1'b0;
      S_DATA:   w_tx_nx = w_shift_nx[0];
      S_PARITY: w_tx_nx = w_par_nx;
      S_STOP:   w_tx_nx = 1'b1;
      default:  w_tx_nx = 1'b1;
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_hold  <= 8'h00;
      r_shift <= 8'h00;
      r_baud  <= '0;
      r_bit   <= 3'd0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_stop  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_hold  <= w_hold_nx;
      r_shift <= w_shift_nx;
      r_baud  <= w_baud_nx;
      r_bit   <= w_bit_nx;
      r_par   <= w_par_nx;
      r_tx    <= w_tx_nx;
      r_busy  <= (w_state_nx != S_IDLE);
      r_stop  <= (w_state_nx == S_STOP);
    end
  end

  assign tx               = r_tx;
  assign tx_busy          = r_busy;
  assign tx_fsm_in_STOP_S = r_stop;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: three instances (even parity, odd parity,
// no parity) share one stimulus stream and each is checked against its own queue.
module tb_uart_tx_frame;

  localparam int BD = 4;

  typedef struct {
    logic [10:0] bits;
    int          nbits;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_data_en = 1'b0;
  logic       tx_send_en = 1'b0;
  logic       tx_send = 1'b0;
  logic [7:0] Tx_Data_w = 8'h00;
  logic [2:0] tx_v, busy_v, stop_v;

  int checks = 0;
  int errors = 0;
  logic [7:0] m_hold = 8'h00;
  frame_t sbq0[$];
  frame_t sbq1[$];
  frame_t sbq2[$];

  always #5 clk = ~clk;

  uart_tx_frame #(.BAUD_DIV(BD), .PARITY_EN(1), .PARITY_ODD(0)) dut_even (
    .clk(clk), .rst_n(rst_n), .tx_data_en(tx_data_en), .tx_send_en(tx_send_en),
    .tx_send(tx_send), .Tx_Data_w(Tx_Data_w),
    .tx(tx_v[0]), .tx_busy(busy_v[0]), .tx_fsm_in_STOP_S(stop_v[0]));

  uart_tx_frame #(.BAUD_DIV(BD), .PARITY_EN(1), .PARITY_ODD(1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .tx_data_en(tx_data_en), .tx_send_en(tx_send_en),
    .tx_send(tx_send), .Tx_Data_w(Tx_Data_w),
    .tx(tx_v[1]), .tx_busy(busy_v[1]), .tx_fsm_in_STOP_S(stop_v[1]));

  uart_tx_frame #(.BAUD_DIV(BD), .PARITY_EN(0), .PARITY_ODD(0)) dut_nopar (
    .clk(clk), .rst_n(rst_n), .tx_data_en(tx_data_en), .tx_send_en(tx_send_en),
    .tx_send(tx_send), .Tx_Data_w(Tx_Data_w),
    .tx(tx_v[2]), .tx_busy(busy_v[2]), .tx_fsm_in_STOP_S(stop_v[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line sequence for one frame, bit 0 first on the wire.
  function automatic frame_t model_frame(input logic [7:0] b, input int d);
    frame_t f;
    f.bits = '0;
    f.bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) f.bits[1+i] = b[i];
    if (d == 2) begin
      f.bits[9] = 1'b1;
      f.nbits   = 10;
    end else begin
      f.bits[9]  = (b[0]^b[1]^b[2]^b[3]^b[4]^b[5]^b[6]^b[7]) ^ (d == 1);
      f.bits[10] = 1'b1;
      f.nbits    = 11;
    end
    return f;
  endfunction

  // Drive one start strobe (optionally with a same-cycle load) for one cycle.
  task automatic send(input logic [7:0] b, input logic load, input logic push);
    if (load) m_hold = b;
    if (push) begin
      sbq0.push_back(model_frame(m_hold, 0));
      sbq1.push_back(model_frame(m_hold, 1));
      sbq2.push_back(model_frame(m_hold, 2));
    end
    tx_data_en = load;
    Tx_Data_w  = b;
    tx_send_en = 1'b1;
    tx_send    = 1'b1;
    @(negedge clk);
    tx_data_en = 1'b0;
    tx_send_en = 1'b0;
    tx_send    = 1'b0;
  endtask

  task automatic load_only(input logic [7:0] b);
    m_hold     = b;
    tx_data_en = 1'b1;
    Tx_Data_w  = b;
    @(negedge clk);
    tx_data_en = 1'b0;
  endtask

  // Sample one frame from instance d starting at the current negedge.
  task automatic capture(input int d);
    frame_t e;
    logic [10:0] got = '0;
    int glitch = 0, busy_n = 0, stop_n = 0, stop_last = 0;
    if (d == 0 ? sbq0.size() == 0 : d == 1 ? sbq1.size() == 0 : sbq2.size() == 0) begin
      check("sb_underflow", 32'd0, 32'd1);
      return;
    end
    e = (d == 0) ? sbq0.pop_front() : (d == 1) ? sbq1.pop_front() : sbq2.pop_front();
    for (int b = 0; b < e.nbits; b++) begin
      for (int c = 0; c < BD; c++) begin
        if (c == 0) got[b] = tx_v[d];
        else if (tx_v[d] !== got[b]) glitch++;
        if (busy_v[d] === 1'b1) busy_n++;
        if (stop_v[d] === 1'b1) begin
          stop_n++;
          if (b == e.nbits - 1) stop_last++;
        end
        @(negedge clk);
      end
    end
    check($sformatf("frame%0d", d), 32'(got), 32'(e.bits));
    check($sformatf("bit_stable%0d", d), glitch, 0);
    check($sformatf("busy_len%0d", d), busy_n, e.nbits * BD);
    check($sformatf("stop_len%0d", d), stop_n, BD);
    check($sformatf("stop_last%0d", d), stop_last, BD);
    check($sformatf("idle_tx%0d", d), 32'(tx_v[d]), 32'd1);
    check($sformatf("idle_busy%0d", d), 32'(busy_v[d]), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s_tx%0d", tag, d), 32'(tx_v[d]), 32'd1);
      check($sformatf("%s_busy%0d", tag, d), 32'(busy_v[d]), 32'd0);
      check($sformatf("%s_stop%0d", tag, d), 32'(stop_v[d]), 32'd0);
    end
  endtask

  initial begin
    int quiet;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Basic frames across the three parity configurations.
    send(8'hA5, 1'b1, 1'b1);
    fork capture(0); capture(1); capture(2); join
    send(8'h01, 1'b1, 1'b1);
    fork capture(0); capture(1); capture(2); join

    // Start strobe during DATA is dropped: exactly one frame, then quiet.
    send(8'h55, 1'b1, 1'b1);
    fork
      capture(0); capture(1); capture(2);
      begin
        repeat (10) @(negedge clk);
        tx_send_en = 1'b1; tx_send = 1'b1;
        @(negedge clk);
        tx_send_en = 1'b0; tx_send = 1'b0;
      end
    join
    quiet = 0;
    repeat (8) begin
      if (busy_v != 3'b000 || tx_v != 3'b111) quiet++;
      @(negedge clk);
    end
    check("no_queued_start", quiet, 0);

    // Send with tx_send = 0 does nothing.
    tx_send_en = 1'b1; tx_send = 1'b0;
    @(negedge clk);
    tx_send_en = 1'b0;
    @(negedge clk);
    check("send_zero_busy", 32'(busy_v), 32'd0);

    // Mid-frame load does not disturb the frame in flight; next start sends it.
    send(8'hC3, 1'b1, 1'b1);
    fork
      capture(0); capture(1); capture(2);
      begin
        repeat (10) @(negedge clk);
        load_only(8'h3C);
      end
    join
    // Back-to-back: start on the first idle cycle of the parity instances.
    send(8'h00, 1'b0, 1'b1);
    fork capture(0); capture(1); capture(2); join

    // Same-cycle load and start sends the new byte.
    repeat (6) @(negedge clk);
    load_only(8'h11);
    send(8'h7E, 1'b1, 1'b1);
    fork capture(0); capture(1); capture(2); join

    // Reset during D3 aborts the frame and clears the holding register.
    repeat (6) @(negedge clk);
    send(8'hF0, 1'b1, 1'b0);
    repeat (17) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_state("midreset");
    rst_n  = 1'b1;
    m_hold = 8'h00;
    @(negedge clk);
    send(8'hFF, 1'b0, 1'b1);
    fork capture(0); capture(1); capture(2); join

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
